debounce_repeat_array: RTL and testbench



---
 rtl/debounce_repeat_array.sv | 191 +++++++++++++++++++
 tb/tb_debounce_repeat_array.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_repeat_array.sv
// ---------------------------------------------------------------------------
// debounce_repeat_array
//
// N-channel push-button conditioner for the 7-segment top level. Every
// channel synchronises its raw button through two flops, debounces press and
// release symmetrically, and produces registered one-cycle press/release
// pulses. A lowest-index encoder lets downstream FSMs take one event per
// cycle.
//
// Optional feature, macro AUTO_REPEAT_EN:
//   defined   - a held button re-emits press_pulse (with repeat_flag) first
//               after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
//   undefined - no repeat counters; only the initial press pulse is emitted
//               and repeat_flag is tied low.
//
// Ports:
//   clk            clock, single domain
//   reset          synchronous, active-high reset
//   btn_raw        [NUM_BTN] asynchronous raw button levels, active high
//   level          [NUM_BTN] debounced button level
//   press_pulse    [NUM_BTN] one-cycle pulse on accepted press or repeat
//   repeat_flag    [NUM_BTN] high together with press_pulse for a repeat
//   release_pulse  [NUM_BTN] one-cycle pulse on accepted release
//   any_event      OR of all press_pulse bits
//   event_idx      [3] lowest channel with press_pulse high, 0 when none
// ---------------------------------------------------------------------------
module debounce_repeat_array #(
    parameter int NUM_BTN      = 4,
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_VAL = 20000,
    parameter int RPT_W        = 24,
    parameter int REPEAT_DELAY = 5000000,
    parameter int REPEAT_RATE  = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] repeat_flag,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic               any_event,
    output logic [2:0]         event_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_VAL - 1);

    logic [NUM_BTN-1:0] s1_q;
    logic [NUM_BTN-1:0] s2_q;

    // Two-flop synchroniser; everything downstream looks only at s2_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
`ifdef AUTO_REPEAT_EN
        localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
        logic [RPT_W-1:0] rpt_q, rpt_d;
        logic             rptSeen_q, rptSeen_d;
        logic             rptFlag_q, rptFlag_d;
`endif

        // Channel state register. Reset throws away any partial debounce or
        // hold progress, so a reset while HELD never produces a release.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
                rpt_q     <= '0;
                rptSeen_q <= 1'b0;
                rptFlag_q <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef AUTO_REPEAT_EN
                rpt_q     <= rpt_d;
                rptSeen_q <= rptSeen_d;
                rptFlag_q <= rptFlag_d;
`endif
            end
        end

        // Next-state logic. The debounce counter runs while the synchronised
        // input disagrees with the accepted level and clears on any agreeing
        // sample, so short glitches never reach the outputs. Repeats only
        // happen on s2=1 cycles, so a release acceptance (s2=0) can never
        // coincide with a repeat.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_d     = rpt_q;
            rptSeen_d = rptSeen_q;
            rptFlag_d = 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (s2_q[g]) begin
                        if (cnt_q == DB_LAST) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            press_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                            rpt_d     = '0;
                            rptSeen_d = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                HELD: begin
                    if (!s2_q[g]) begin
                        if (cnt_q == DB_LAST) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
`ifdef AUTO_REPEAT_EN
                        // First repeat waits the long delay, later ones the
                        // shorter rate; the counter saturates rather than wraps.
                        if (rpt_q == (rptSeen_q ? RATE_LAST : DELAY_LAST)) begin
                            press_d   = 1'b1;
                            rptFlag_d = 1'b1;
                            rpt_d     = '0;
                            rptSeen_d = 1'b1;
                        end else if (rpt_q != {RPT_W{1'b1}}) begin
                            rpt_d = rpt_q + 1'b1;
                        end
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign level[g]         = (state_q == HELD);
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
`ifdef AUTO_REPEAT_EN
        assign repeat_flag[g]   = rptFlag_q;
`else
        assign repeat_flag[g]   = 1'b0;
`endif
    end

    // Lowest-index priority encoder over the registered press pulses;
    // scanning downward lets the lowest set bit win.
    always_comb begin
        event_idx = 3'd0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_pulse[i]) begin
                event_idx = 3'(i);
            end
        end
    end

    assign any_event = |press_pulse;

endmodule

// File: tb/tb_debounce_repeat_array.sv
// ---------------------------------------------------------------------------
// tb_debounce_repeat_array
//
// Directed bench for debounce_repeat_array with NUM_BTN=4, DEBOUNCE_VAL=4,
// REPEAT_DELAY=20, REPEAT_RATE=8. Inputs change 1 time unit after a rising
// edge and outputs are compared at that same point, so "after edge N" in the
// comments below means the check that follows the (N+1)th stepClock after
// the stimulus change. Expected repeat behaviour follows AUTO_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_debounce_repeat_array;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] level;
    logic [3:0] press_pulse;
    logic [3:0] repeat_flag;
    logic [3:0] release_pulse;
    logic       any_event;
    logic [2:0] event_idx;

    int checkCount = 0;
    int errorCount = 0;

    // 10-unit clock period
    always #5 clk = ~clk;

    debounce_repeat_array #(
        .NUM_BTN      (4),
        .CNT_W        (8),
        .DEBOUNCE_VAL (4),
        .RPT_W        (8),
        .REPEAT_DELAY (20),
        .REPEAT_RATE  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .level         (level),
        .press_pulse   (press_pulse),
        .repeat_flag   (repeat_flag),
        .release_pulse (release_pulse),
        .any_event     (any_event),
        .event_idx     (event_idx)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] raw);
        btn_raw = raw;
    endtask

    task automatic stepClock(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Checks every output is at its idle value
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_level"},   8'(level),         8'h00);
        checkOutput({tag, "_press"},   8'(press_pulse),   8'h00);
        checkOutput({tag, "_release"}, 8'(release_pulse), 8'h00);
        checkOutput({tag, "_repeat"},  8'(repeat_flag),   8'h00);
        checkOutput({tag, "_any"},     8'(any_event),     8'h00);
        checkOutput({tag, "_idx"},     8'(event_idx),     8'h00);
    endtask

    initial begin
        logic autoRpt;
        logic expPress;
`ifdef AUTO_REPEAT_EN
        autoRpt = 1'b1;
`else
        autoRpt = 1'b0;
`endif
        $display("[TB] start, auto-repeat=%0d", autoRpt);

        // Reset state
        reset = 1'b1;
        applyStimulus(4'b0000);
        stepClock(2);
        checkAllZero("reset");
        reset = 1'b0;

        // Scenario 1: clean press on channel 0, accepted after edge 5
        applyStimulus(4'b0001);
        stepClock(5);
        checkOutput("s1_level_early", 8'(level), 8'h00);
        checkOutput("s1_press_early", 8'(press_pulse), 8'h00);
        stepClock(1);
        checkOutput("s1_level",  8'(level),       8'h01);
        checkOutput("s1_press",  8'(press_pulse), 8'h01);
        checkOutput("s1_repeat", 8'(repeat_flag), 8'h00);
        checkOutput("s1_any",    8'(any_event),   8'h01);
        checkOutput("s1_idx",    8'(event_idx),   8'h00);
        stepClock(1);
        checkOutput("s1_press_end", 8'(press_pulse), 8'h00);
        checkOutput("s1_level_hold", 8'(level), 8'h01);
        applyStimulus(4'b0000);
        stepClock(5);
        checkOutput("s1_release_early", 8'(release_pulse), 8'h00);
        stepClock(1);
        checkOutput("s1_release", 8'(release_pulse), 8'h01);
        checkOutput("s1_level_off", 8'(level), 8'h00);
        stepClock(1);
        checkOutput("s1_release_end", 8'(release_pulse), 8'h00);

        // Scenario 2: 3-cycle bounce is rejected
        applyStimulus(4'b0010);
        stepClock(3);
        applyStimulus(4'b0000);
        for (int k = 0; k < 10; k++) begin
            stepClock(1);
            checkOutput("s2_short", {level, press_pulse}, 8'h00);
        end
        // Scenario 2b: accepted press, then a 1-cycle low glitch is ignored
        applyStimulus(4'b0010);
        stepClock(6);
        checkOutput("s2_press", 8'(press_pulse), 8'h02);
        applyStimulus(4'b0000);
        stepClock(1);
        applyStimulus(4'b0010);
        for (int k = 0; k < 10; k++) begin
            stepClock(1);
            checkOutput("s2_glitch", {level, release_pulse}, 8'h20);
        end
        applyStimulus(4'b0000);
        stepClock(6);
        checkOutput("s2_release", 8'(release_pulse), 8'h02);
        stepClock(2);

        // Scenario 3/4: hold channel 2; repeats at +20,+28,... when enabled.
        // Raw falls after tick 56, so release lands 5 edges later at +62.
        applyStimulus(4'b0100);
        stepClock(6);
        checkOutput("s3_press",  8'(press_pulse), 8'h04);
        checkOutput("s3_repeat", 8'(repeat_flag), 8'h00);
        for (int k = 1; k <= 63; k++) begin
            stepClock(1);
            if (k == 56) applyStimulus(4'b0000);
            expPress = autoRpt && (k == 20 || k == 28 || k == 36 || k == 44 || k == 52);
            checkOutput($sformatf("s3_k%0d", k),
                        {4'h0, press_pulse[2], repeat_flag[2], release_pulse[2], any_event},
                        {4'h0, expPress, expPress, (k == 62), expPress});
            if (expPress) checkOutput("s3_idx", 8'(event_idx), 8'h02);
        end

        // Scenario 5: simultaneous press on channels 3 and 1
        applyStimulus(4'b1010);
        stepClock(6);
        checkOutput("s5_press", 8'(press_pulse), 8'h0A);
        checkOutput("s5_idx",   8'(event_idx),   8'h01);
        checkOutput("s5_any",   8'(any_event),   8'h01);
        checkOutput("s5_level", 8'(level),       8'h0A);
        applyStimulus(4'b0000);
        stepClock(6);
        checkOutput("s5_release", 8'(release_pulse), 8'h0A);
        stepClock(2);

        // Scenario 6: reset while channel 0 is HELD, then re-acceptance
        applyStimulus(4'b0001);
        stepClock(6);
        checkOutput("s6_level", 8'(level), 8'h01);
        stepClock(2);
        reset = 1'b1;
        stepClock(1);
        reset = 1'b0;
        checkAllZero("s6_reset");
        for (int k = 0; k < 5; k++) begin
            stepClock(1);
            checkOutput("s6_wait", {level, release_pulse}, 8'h00);
        end
        stepClock(1);
        checkOutput("s6_repress", {level, press_pulse}, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
